// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side read port of the buffered UART receiver (FIFO head plus status).
interface uart_rx_buffered_if #(
    parameter int DataBitsSize = 8,
    parameter int BufferSize   = 16
);
    logic                          rd_valid;
    logic                          rd_ready;
    logic [DataBitsSize-1:0]       rd_data;
    logic                          rd_parity_err;
    logic                          rd_frame_err;
    logic [$clog2(BufferSize):0]   count;
    logic                          overflow;
    logic                          clear_overflow;

    modport master (
        output rd_valid, rd_data, rd_parity_err, rd_frame_err, count, overflow,
        input  rd_ready, clear_overflow
    );

    modport slave (
        input  rd_valid, rd_data, rd_parity_err, rd_frame_err, count, overflow,
        output rd_ready, clear_overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered write, show-ahead read, exact occupancy count.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [Width-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [Width-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);
    localparam int AddrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr_reg;
    logic [AddrW-1:0] rd_ptr_reg;
    logic [AddrW:0]   count_reg;
    logic             wr_do;
    logic             rd_do;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AddrW + 1)'(Depth));
    assign rd_do = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_do = wr_en && (!full || rd_do);

    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_do) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_do) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_do, rd_do})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset, so the head reads as zero whenever nothing is held.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];
    assign count   = count_reg;
endmodule

// File: rtl/uart_rx_buffered.sv
// UART deserializer with start-glitch rejection, parity/framing flags and a receive FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int ClockFreqHz  = 100_000_000,
    parameter int BaudRate     = 115_200,
    parameter int DataBitsSize = 8,
    parameter int ParityMode   = 0,
    parameter int StopBitsSize = 1,
    parameter int BufferSize   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_sig,
    uart_rx_buffered_if.master  rd
);
    localparam int ClksPerBit = clks_per_bit(ClockFreqHz, BaudRate);
    localparam int CntW       = $clog2(ClksPerBit);

    if (ClksPerBit < 4) begin : g_bad_clks
        $error("uart_rx_buffered: ClksPerBit must be at least 4");
    end
    if (DataBitsSize < 5 || DataBitsSize > 9) begin : g_bad_data
        $error("uart_rx_buffered: DataBitsSize must be 5..9");
    end
    if (StopBitsSize < 1 || StopBitsSize > 2) begin : g_bad_stop
        $error("uart_rx_buffered: StopBitsSize must be 1..2");
    end
    if (BufferSize < 2 || (BufferSize & (BufferSize - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_buffered: BufferSize must be a power of two >= 2");
    end

    typedef struct packed {
        logic                    frame_err;
        logic                    parity_err;
        logic [DataBitsSize-1:0] data;
    } rx_entry_t;

    localparam int EntryW = $bits(rx_entry_t);

    rx_state_e               state_reg;
    logic [1:0]              sync_reg;
    logic                    rx_prev_reg;
    logic [CntW-1:0]         baud_cnt_reg;
    logic [3:0]              bit_cnt_reg;
    logic                    stop_cnt_reg;
    logic [DataBitsSize-1:0] data_reg;
    logic                    parity_err_reg;
    logic                    frame_err_reg;
    logic                    overflow_reg;

    logic                    rx_s;
    logic                    tick;
    logic                    push;
    logic                    pop;
    rx_entry_t               push_word;
    rx_entry_t               head;
    logic [EntryW-1:0]       fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign rx_s = sync_reg[1];
    assign tick = (baud_cnt_reg == '0);
    // The word leaves on the last stop-bit sample; the remainder of that bit is not waited for.
    assign push = (state_reg == STOP) && tick && (stop_cnt_reg == 1'(StopBitsSize - 1));
    assign pop  = rd.rd_ready && !fifo_empty;

    assign push_word.frame_err  = frame_err_reg | ~rx_s;
    assign push_word.parity_err = parity_err_reg;
    assign push_word.data       = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b11;
            rx_prev_reg    <= 1'b1;
            state_reg      <= IDLE;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            data_reg       <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], rx_sig};
            rx_prev_reg <= rx_s;
            if (state_reg != IDLE && !tick) begin
                baud_cnt_reg <= baud_cnt_reg - 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        state_reg    <= START;
                        baud_cnt_reg <= CntW'(ClksPerBit / 2 - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg      <= DATA;
                            baud_cnt_reg   <= CntW'(ClksPerBit - 1);
                            bit_cnt_reg    <= '0;
                            parity_err_reg <= 1'b0;
                            frame_err_reg  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        data_reg     <= {rx_s, data_reg[DataBitsSize-1:1]};
                        baud_cnt_reg <= CntW'(ClksPerBit - 1);
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 4'(DataBitsSize - 1)) begin
                            state_reg    <= (ParityMode != int'(PARITY_NONE)) ? PARITY : STOP;
                            stop_cnt_reg <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (ParityMode == int'(PARITY_ODD)) begin
                            parity_err_reg <= ~(^{data_reg, rx_s});
                        end else begin
                            parity_err_reg <= ^{data_reg, rx_s};
                        end
                        state_reg    <= STOP;
                        baud_cnt_reg <= CntW'(ClksPerBit - 1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        frame_err_reg <= frame_err_reg | ~rx_s;
                        if (push) begin
                            state_reg <= IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                            baud_cnt_reg <= CntW'(ClksPerBit - 1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A new overflow event takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end else if (rd.clear_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    sync_fifo #(
        .Width (EntryW),
        .Depth (BufferSize)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rd.count)
    );

    assign head             = fifo_rd_data;
    assign rd.rd_valid      = !fifo_empty;
    assign rd.rd_data       = head.data;
    assign rd.rd_parity_err = head.parity_err;
    assign rd.rd_frame_err  = head.frame_err;
    assign rd.overflow      = overflow_reg;
endmodule
